// File: rtl/trap_ctrl_if.sv
// E-stage exception/mret inputs and trap/redirect outputs of the trap sequencer.
// The master side is the pipeline; the slave side is trap_ctrl.
interface trap_ctrl_if #(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = 32
);
  logic             exc_valid;
  logic [6:0]       except_signal;
  logic [N-1:0]     exc_pc;
  logic [N-1:0]     exc_addr;
  logic             mret;
  logic [N-1:0]     mtvec;

  logic             stall;
  logic             flush;
  logic             redirect_valid;
  logic [N-1:0]     redirect_pc;
  logic [N-1:0]     mepc;
  logic [N-1:0]     mcause;
  logic [N-1:0]     mtval;
  logic [CNT_W-1:0] trap_count;

  modport master (
    output exc_valid, except_signal, exc_pc, exc_addr, mret, mtvec,
    input  stall, flush, redirect_valid, redirect_pc, mepc, mcause, mtval, trap_count
  );

  modport slave (
    input  exc_valid, except_signal, exc_pc, exc_addr, mret, mtvec,
    output stall, flush, redirect_valid, redirect_pc, mepc, mcause, mtval, trap_count
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer: prioritises E-stage memory/breakpoint exceptions, then sequences
// flush, mepc/mcause/mtval update and redirect to mtvec; also sequences mret returns.
module trap_ctrl #(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  trap_ctrl_if.slave bus
);

  localparam int unsigned CAUSE_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_SAVE   = 3'd2,
    S_VECTOR = 3'd3,
    S_RET    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               stall_q, stall_d;
  logic               flush_q, flush_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [N-1:0]       redirect_pc_q, redirect_pc_d;
  logic [N-1:0]       mepc_q, mepc_d;
  logic [N-1:0]       mcause_q, mcause_d;
  logic [N-1:0]       mtval_q, mtval_d;
  logic [CNT_W-1:0]   trap_count_q, trap_count_d;

  // Trap context captured at acceptance, held until committed in SAVE.
  logic [CAUSE_W-1:0] lat_cause_q, lat_cause_d;
  logic [N-1:0]       lat_pc_q, lat_pc_d;
  logic [N-1:0]       lat_tval_q, lat_tval_d;
  logic [N-1:0]       lat_tvec_q, lat_tvec_d;

  logic               any_exc_c;
  logic               trap_req_c;
  logic               ret_req_c;
  logic [CAUSE_W-1:0] cause_code_c;
  logic               tval_is_pc_c;

  assign any_exc_c  = |bus.except_signal;
  assign trap_req_c = bus.exc_valid & any_exc_c;
  assign ret_req_c  = bus.exc_valid & bus.mret & ~any_exc_c;

  // Fixed-priority cause select; only breakpoint reports the PC as mtval.
  always_comb begin
    cause_code_c = '0;
    tval_is_pc_c = 1'b0;
    if (bus.except_signal[6]) begin
      cause_code_c = CAUSE_W'(3);
      tval_is_pc_c = 1'b1;
    end else if (bus.except_signal[2]) begin
      cause_code_c = CAUSE_W'(6);
    end else if (bus.except_signal[0]) begin
      cause_code_c = CAUSE_W'(4);
    end else if (bus.except_signal[5]) begin
      cause_code_c = CAUSE_W'(15);
    end else if (bus.except_signal[4]) begin
      cause_code_c = CAUSE_W'(13);
    end else if (bus.except_signal[3]) begin
      cause_code_c = CAUSE_W'(7);
    end else if (bus.except_signal[1]) begin
      cause_code_c = CAUSE_W'(5);
    end
  end

  // Next state; outputs are computed for the state being entered so they register cleanly.
  always_comb begin
    state_d          = state_q;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    trap_count_d     = trap_count_q;
    lat_cause_d      = lat_cause_q;
    lat_pc_d         = lat_pc_q;
    lat_tval_d       = lat_tval_q;
    lat_tvec_d       = lat_tvec_q;

    unique case (state_q)
      S_IDLE: begin
        if (trap_req_c) begin
          state_d     = S_FLUSH;
          flush_d     = 1'b1;
          lat_cause_d = cause_code_c;
          lat_pc_d    = bus.exc_pc;
          lat_tval_d  = tval_is_pc_c ? bus.exc_pc : bus.exc_addr;
          lat_tvec_d  = bus.mtvec & ~(N'(2'b11));
        end else if (ret_req_c) begin
          state_d          = S_RET;
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = mepc_q;
        end
      end
      S_FLUSH: begin
        state_d = S_SAVE;
      end
      S_SAVE: begin
        state_d          = S_VECTOR;
        mepc_d           = lat_pc_q;
        mcause_d         = N'(lat_cause_q);
        mtval_d          = lat_tval_q;
        trap_count_d     = trap_count_q + CNT_W'(1);
        redirect_valid_d = 1'b1;
        redirect_pc_d    = lat_tvec_q;
      end
      S_VECTOR: begin
        state_d = S_IDLE;
      end
      S_RET: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    stall_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      stall_q          <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      trap_count_q     <= '0;
      lat_cause_q      <= '0;
      lat_pc_q         <= '0;
      lat_tval_q       <= '0;
      lat_tvec_q       <= '0;
    end else begin
      state_q          <= state_d;
      stall_q          <= stall_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      trap_count_q     <= trap_count_d;
      lat_cause_q      <= lat_cause_d;
      lat_pc_q         <= lat_pc_d;
      lat_tval_q       <= lat_tval_d;
      lat_tvec_q       <= lat_tvec_d;
    end
  end

  assign bus.stall          = stall_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.mepc           = mepc_q;
  assign bus.mcause         = mcause_q;
  assign bus.mtval          = mtval_q;
  assign bus.trap_count     = trap_count_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed vectors and sequences plus randomized traffic,
// all checked every cycle against a timeline-based reference model.
module tb_trap_ctrl;

  localparam int unsigned N      = 64;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned CNT_W4 = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  trap_ctrl_if #(.N(N), .CNT_W(CNT_W))  bus ();
  trap_ctrl_if #(.N(N), .CNT_W(CNT_W4)) bus4 ();

  assign bus4.exc_valid     = bus.exc_valid;
  assign bus4.except_signal = bus.except_signal;
  assign bus4.exc_pc        = bus.exc_pc;
  assign bus4.exc_addr      = bus.exc_addr;
  assign bus4.mret          = bus.mret;
  assign bus4.mtvec         = bus.mtvec;

  trap_ctrl #(.N(N), .CNT_W(CNT_W))  dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  trap_ctrl #(.N(N), .CNT_W(CNT_W4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  int n_checks = 0;
  int n_pass   = 0;

  // Model: each accepted request schedules its effects on an absolute cycle timeline.
  int          cyc = 0;
  int          flush_at, rv_at, csr_at, stall_from, busy_end;
  logic [63:0] m_mepc, m_mcause, m_mtval, m_rpc;
  logic [63:0] p_pc, p_cause, p_tval, p_rpc;
  logic [31:0] m_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void cause_of(input logic [6:0] s, input logic [63:0] pc,
                                   input logic [63:0] addr, output logic [63:0] code,
                                   output logic [63:0] tval);
    int order [7] = '{6, 2, 0, 5, 4, 3, 1};
    int codes [7] = '{3, 6, 4, 15, 13, 7, 5};
    bit found = 1'b0;
    code = '0;
    tval = '0;
    for (int i = 0; i < 7; i++) begin
      if (!found && s[order[i]]) begin
        found = 1'b1;
        code  = 64'(codes[i]);
        tval  = (order[i] == 6) ? pc : addr;
      end
    end
  endfunction

  task automatic model_edge();
    cyc++;
    if (reset) begin
      flush_at = -1; rv_at = -1; csr_at = -1; stall_from = 0; busy_end = -1;
      m_mepc = '0; m_mcause = '0; m_mtval = '0; m_rpc = '0; m_count = '0;
    end else begin
      if ((cyc - 1 > busy_end) && bus.exc_valid && (bus.except_signal != 7'd0)) begin
        cause_of(bus.except_signal, bus.exc_pc, bus.exc_addr, p_cause, p_tval);
        p_pc       = bus.exc_pc;
        p_rpc      = {bus.mtvec[63:2], 2'b00};
        flush_at   = cyc;
        stall_from = cyc;
        busy_end   = cyc + 2;
        rv_at      = cyc + 2;
        csr_at     = cyc + 2;
      end else if ((cyc - 1 > busy_end) && bus.exc_valid && bus.mret) begin
        p_rpc      = m_mepc;
        flush_at   = cyc;
        stall_from = cyc;
        busy_end   = cyc;
        rv_at      = cyc;
      end
      if (cyc == csr_at) begin
        m_mepc   = p_pc;
        m_mcause = p_cause;
        m_mtval  = p_tval;
        m_count  = m_count + 32'd1;
      end
      if (cyc == rv_at) m_rpc = p_rpc;
    end
  endtask

  // One clock: DUT and model see the same inputs at the edge; outputs compared 1ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("stall",       64'(bus.stall),          64'((cyc >= stall_from) && (cyc <= busy_end)));
    check("flush",       64'(bus.flush),          64'(cyc == flush_at));
    check("redir_valid", 64'(bus.redirect_valid), 64'(cyc == rv_at));
    check("redir_pc",    bus.redirect_pc,         m_rpc);
    check("mepc",        bus.mepc,                m_mepc);
    check("mcause",      bus.mcause,              m_mcause);
    check("mtval",       bus.mtval,               m_mtval);
    check("trap_count",  64'(bus.trap_count),     64'(m_count));
    check("trap_count4", 64'(bus4.trap_count),    64'(m_count[3:0]));
  endtask

  task automatic drive(input logic v, input logic [6:0] s, input logic [63:0] pc,
                       input logic [63:0] addr, input logic r);
    bus.exc_valid     = v;
    bus.except_signal = s;
    bus.exc_pc        = pc;
    bus.exc_addr      = addr;
    bus.mret          = r;
  endtask

  task automatic idle_in();
    drive(1'b0, 7'd0, 64'd0, 64'd0, 1'b0);
  endtask

  typedef struct {
    logic [6:0]  sig;
    logic [63:0] pc;
    logic [63:0] addr;
    logic        mret;
    logic [63:0] exp_cause;
    logic [63:0] exp_tval;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{7'b1101011, 64'h40,   64'h5000, 1'b0, 64'd3,  64'h40};
    vecs[1]  = '{7'b0101010, 64'h44,   64'h5008, 1'b0, 64'd15, 64'h5008};
    vecs[2]  = '{7'b0000001, 64'h100,  64'h7001, 1'b0, 64'd4,  64'h7001};
    vecs[3]  = '{7'b0000010, 64'h104,  64'h7100, 1'b0, 64'd5,  64'h7100};
    vecs[4]  = '{7'b0000100, 64'h108,  64'h7202, 1'b1, 64'd6,  64'h7202};
    vecs[5]  = '{7'b0001000, 64'h10c,  64'h7300, 1'b0, 64'd7,  64'h7300};
    vecs[6]  = '{7'b0010000, 64'h110,  64'h7400, 1'b0, 64'd13, 64'h7400};
    vecs[7]  = '{7'b0100000, 64'h114,  64'h7500, 1'b0, 64'd15, 64'h7500};
    vecs[8]  = '{7'b1000000, 64'h118,  64'h7600, 1'b0, 64'd3,  64'h118};
    vecs[9]  = '{7'b0011010, 64'h11c,  64'h7700, 1'b0, 64'd13, 64'h7700};
    vecs[10] = '{7'b0001010, 64'h120,  64'h7800, 1'b0, 64'd7,  64'h7800};
    vecs[11] = '{7'b0100101, 64'h124,  64'h7903, 1'b0, 64'd6,  64'h7903};

    reset = 1'b1;
    idle_in();
    bus.mtvec = 64'h8001;
    flush_at = -1; rv_at = -1; csr_at = -1; stall_from = 0; busy_end = -1;
    m_mepc = '0; m_mcause = '0; m_mtval = '0; m_rpc = '0; m_count = '0;
    p_pc = '0; p_cause = '0; p_tval = '0; p_rpc = '0;
    step();
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_count", 64'(bus.trap_count), 64'd0);
    reset = 1'b0;
    step();

    // Reset while in SAVE aborts the trap with no CSR update.
    drive(1'b1, 7'b0000001, 64'h1000, 64'h2003, 1'b0);
    step();
    idle_in();
    step();
    check("save_stall", 64'(bus.stall), 64'd1);
    reset = 1'b1;
    step();
    check("abort_stall", 64'(bus.stall), 64'd0);
    check("abort_rv",    64'(bus.redirect_valid), 64'd0);
    check("abort_mepc",  bus.mepc, 64'd0);
    check("abort_count", 64'(bus.trap_count), 64'd0);
    reset = 1'b0;
    step();

    // Load misalign with full latency profile.
    drive(1'b1, 7'b0000001, 64'h1000, 64'h2003, 1'b0);
    step();
    idle_in();
    check("lm_flush_t1", 64'(bus.flush), 64'd1);
    step();
    check("lm_flush_t2", 64'(bus.flush), 64'd0);
    check("lm_stall_t2", 64'(bus.stall), 64'd1);
    step();
    check("lm_mepc",   bus.mepc, 64'h1000);
    check("lm_mcause", bus.mcause, 64'd4);
    check("lm_mtval",  bus.mtval, 64'h2003);
    check("lm_rv",     64'(bus.redirect_valid), 64'd1);
    check("lm_rpc",    bus.redirect_pc, 64'h8000);
    check("lm_count",  64'(bus.trap_count), 64'd1);
    step();
    check("lm_stall_t4", 64'(bus.stall), 64'd0);

    // mret returns to mepc without counting.
    drive(1'b1, 7'd0, 64'h3000, 64'h0, 1'b1);
    step();
    idle_in();
    check("ret_flush", 64'(bus.flush), 64'd1);
    check("ret_rv",    64'(bus.redirect_valid), 64'd1);
    check("ret_rpc",   bus.redirect_pc, 64'h1000);
    check("ret_count", 64'(bus.trap_count), 64'd1);
    step();
    check("ret_rv_off",  64'(bus.redirect_valid), 64'd0);
    check("ret_rpc_hold", bus.redirect_pc, 64'h1000);

    // mret together with an exception takes the trap; request held through the sequence.
    drive(1'b1, 7'b0000100, 64'h1100, 64'h2206, 1'b1);
    for (int i = 0; i < 4; i++) step();
    idle_in();
    step();
    step();
    check("held_mcause", bus.mcause, 64'd6);
    check("held_count",  64'(bus.trap_count), 64'd2);

    // No valid instruction: exception bits ignored.
    drive(1'b0, 7'b1111111, 64'h1200, 64'h2300, 1'b1);
    for (int i = 0; i < 3; i++) step();
    check("novalid_stall", 64'(bus.stall), 64'd0);
    check("novalid_count", 64'(bus.trap_count), 64'd2);
    idle_in();
    step();

    // Priority table.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].sig, vecs[i].pc, vecs[i].addr, vecs[i].mret);
      step();
      idle_in();
      step();
      step();
      check($sformatf("tbl%0d_mcause", i), bus.mcause, vecs[i].exp_cause);
      check($sformatf("tbl%0d_mtval", i),  bus.mtval,  vecs[i].exp_tval);
      check($sformatf("tbl%0d_mepc", i),   bus.mepc,   vecs[i].pc);
      step();
    end

    // 16 back-to-back traps from reset: 4-bit counter wraps to 0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 7'b0010000, 64'h9000, 64'hA000, 1'b0);
    for (int i = 0; i < 64; i++) step();
    idle_in();
    step();
    check("wrap_count4", 64'(bus4.trap_count), 64'd0);
    check("wrap_count",  64'(bus.trap_count), 64'd16);

    // Randomized traffic against the model.
    for (int blk = 0; blk < 3; blk++) begin
      bus.mtvec = {$urandom, $urandom};
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 600; i++) begin
        drive($urandom_range(0, 3) != 0,
              ($urandom_range(0, 1) != 0) ? 7'($urandom) : 7'd0,
              {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 2) == 0);
        reset = ($urandom_range(0, 99) == 0);
        step();
      end
      reset = 1'b0;
      idle_in();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Trap sequencer for the pipeline's synchronous memory and breakpoint exceptions. Consumes the 7-bit exception vector produced at the Execute stage together with the faulting PC and data-memory address. Prioritises the exception cause and sequences flush, trap-CSR update (mepc/mcause/mtval) and redirect to mtvec. Also sequences mret returns. Sits between the E-stage exception logic, the hazard/flush unit and the fetch PC mux.

Parameters:
N, 64, datapath/address width
CNT_W, 32, width of trap counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
exc_valid  in  1  E-stage slot holds a valid instruction this cycle
except_signal  in  7  bit0 load misalign, bit1 load access fault, bit2 store misalign, bit3 store access fault, bit4 load page fault, bit5 store page fault, bit6 breakpoint
exc_pc  in  N  PC of the E-stage instruction
exc_addr  in  N  data-memory address of the E-stage instruction
mret  in  1  E-stage instruction is a valid mret
mtvec  in  N  trap vector base from CSR file
stall  out  1  freeze upstream stages; high whenever state != IDLE
flush  out  1  one-cycle pulse that kills F/D/E and squashes the faulting memory op
redirect_valid  out  1  one-cycle pulse; fetch loads redirect_pc
redirect_pc  out  N  new fetch PC
mepc  out  N  trap PC register
mcause  out  N  trap cause register
mtval  out  N  trap value register
trap_count  out  CNT_W  number of traps taken (mret is not counted)

Behaviour:
- Reset (synchronous, active-high): state=IDLE; stall, flush and redirect_valid are 0; redirect_pc, mepc, mcause, mtval and trap_count are 0. Reset takes priority in any state and aborts an in-flight sequence with no CSR update.
- trap_req = exc_valid & |except_signal. ret_req = exc_valid & mret & ~|except_signal.
- States: IDLE, FLUSH, SAVE, VECTOR, RET.
- IDLE:
  - trap_req: latch the cause, pc and addr; go to FLUSH.
  - else ret_req: go to RET.
  - else stay in IDLE.
  - trap_req beats mret in the same cycle.
- FLUSH: flush=1 for this cycle. Go to SAVE.
- SAVE: on the clock edge leaving SAVE, write mepc=latched pc, mcause and mtval as below, and increment trap_count (wraps modulo 2^CNT_W). Go to VECTOR.
- VECTOR: redirect_valid=1 and redirect_pc={mtvec[N-1:2],2'b00}. Go to IDLE.
- RET: flush=1, redirect_valid=1 and redirect_pc=mepc, all in the same cycle. No CSR change. Go to IDLE.
- Trap latency: trap_req sampled at edge t. flush is high in cycle t+1. The CSRs are visible in cycle t+3, where redirect_valid is also high. stall is high during cycles t+1..t+3.
- Cause priority, highest first, one cause only:
  - bit6 breakpoint: mcause=3, mtval=exc_pc.
  - bit2 store misalign: mcause=6.
  - bit0 load misalign: mcause=4.
  - bit5 store page fault: mcause=15.
  - bit4 load page fault: mcause=13.
  - bit3 store access fault: mcause=7.
  - bit1 load access fault: mcause=5.
  - Every cause other than breakpoint sets mtval=exc_addr.
  - mcause is zero-extended to N; the interrupt bit is always 0.
- All inputs are ignored while state != IDLE; exceptions arriving then are dropped, because the pipeline is stalled or flushed.
- The redirect_pc register holds its last value when redirect_valid=0.
- A trap taken in the cycle after a VECTOR redirect is legal: IDLE is re-entered and the next trap_req is accepted normally (back-to-back traps).

Test Plan:
- Reset mid-sequence: assert reset while in SAVE → next cycle state=IDLE; all outputs 0; mepc unchanged at 0; trap_count=0.
- Load misalign: exc_valid=1, except_signal=7'b0000001, exc_pc=0x1000, exc_addr=0x2003, mtvec=0x8001 → flush in cycle t+1; in t+3 mepc=0x1000, mcause=4, mtval=0x2003, redirect_valid=1, redirect_pc=0x8000, trap_count=1.
- Priority: except_signal=7'b1101011, exc_pc=0x40 → mcause=3, mtval=0x40. Repeat with 7'b0101010 → mcause=15.
- mret: after the above trap, exc_valid=1, mret=1, except_signal=0 → next cycle flush=1, redirect_valid=1, redirect_pc=mepc; trap_count unchanged.
- Simultaneous/ignored inputs: mret=1 together with except_signal=7'b0000100 → trap path taken with mcause=6. A trap_req held high through FLUSH/SAVE/VECTOR → exactly one trap taken and trap_count increments by 1 only. exc_valid=0 with except_signal nonzero → no action.
- Counter wrap (CNT_W=4): 16 back-to-back traps → trap_count returns to 0.
